top_entity: RTL and testbench

Hardware runtime monitor for a fixed specification over two 64-bit signed input streams, `a` and `b`. A high-level controller (HLC) turns input arrivals and periodic deadlines into tagged events and pushes them into a FIFO. A low-level controller (LLC) pops the events and evaluates three output streams: an event-based sum, a periodic sliding-window sum, and an event-based offset lookup. The block is the complete monitor top level, and its internal state is exposed on debug ports.

---
 rtl/top_entity_pkg.sv | 18 +
 rtl/top_entity_event_fifo.sv | 57 +++++
 rtl/top_entity.sv | 183 ++++++++++++++++++
 tb/tb_top_entity.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/top_entity_pkg.sv
// Shared types and default constants for the two-stream runtime monitor.
package top_entity_pkg;

  localparam int unsigned DEF_PERIOD_CYCLES = 500;
  localparam int unsigned DEF_QDEPTH        = 4;

  typedef logic signed [63:0] val_t;

  typedef struct packed {
    logic [63:0] tag;
    val_t        a;
    val_t        b;
    logic        a_present;
    logic        b_present;
    logic        periodic;
  } event_t;

endpackage

// File: rtl/top_entity_event_fifo.sv
// Synchronous FIFO with first-word fall-through read data and full/empty flags.
module event_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= f_inc(r_wptr);
      if (w_pop_ok)  r_rptr <= f_inc(r_rptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/top_entity.sv
// Runtime monitor top: HLC builds tagged events into a FIFO, LLC evaluates
// output_0 = a+b, output_1 = 3-period window sum, output_2 = output_0.offset(-2).
module top_entity
  import top_entity_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned QDEPTH        = DEF_QDEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] input_0,
  input  logic        new_input_0,
  input  logic [63:0] input_1,
  input  logic        new_input_1,
  output logic [63:0] output_0,
  output logic        output_0_aktv,
  output logic [63:0] output_1,
  output logic        output_1_aktv,
  output logic [63:0] output_2,
  output logic        output_2_aktv,
  output logic [63:0] llc_tag,
  output logic        q_push,
  output logic        q_pop,
  output logic        q_push_valid,
  output logic        q_pop_valid,
  output logic        pacing_0,
  output logic        pacing_1,
  output logic        pacing_2,
  output logic        slide_0,
  output logic [63:0] sw0_tag,
  output logic [63:0] sw0_v1,
  output logic [63:0] sw0_v2,
  output logic [63:0] sw0_v3,
  output logic [63:0] out0_data0_tag,
  output logic [63:0] out0_data0_int,
  output logic [63:0] out0_data1_tag,
  output logic [63:0] out0_data1_int,
  output logic [63:0] out0_tag1,
  output logic [63:0] out0_v1,
  output logic [63:0] out0_tag2,
  output logic [63:0] out0_v2,
  output logic [63:0] out0_tag3,
  output logic [63:0] out0_v3
);

  logic [31:0] r_cyc;
  logic [63:0] r_tag;
  logic        r_s1_valid;
  logic        w_deadline;
  logic        w_event_req;
  logic        w_full;
  logic        w_empty;
  logic        w_both;
  event_t      w_ev_in;
  event_t      w_ev_out;
  logic [63:0] w_o0;
  logic [63:0] w_bucket;

  // HLC: deadline counter and the clock enable pause together; input arrivals
  // still create events while en is low so the FIFO can fill and drop.
  assign w_deadline  = en && (r_cyc == 32'(PERIOD_CYCLES - 1));
  assign w_event_req = new_input_0 || new_input_1 || w_deadline;

  always_comb begin
    w_ev_in           = '0;
    w_ev_in.tag       = r_tag + 64'd1;
    w_ev_in.a         = val_t'(input_0);
    w_ev_in.b         = val_t'(input_1);
    w_ev_in.a_present = new_input_0;
    w_ev_in.b_present = new_input_1;
    w_ev_in.periodic  = w_deadline;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc <= '0;
      r_tag <= '0;
    end else begin
      if (en)          r_cyc <= w_deadline ? '0 : r_cyc + 32'd1;
      if (w_event_req) r_tag <= r_tag + 64'd1;
    end
  end

  event_fifo #(
    .WIDTH ($bits(event_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_event_req),
    .i_data  (w_ev_in),
    .i_pop   (en),
    .o_data  (w_ev_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign q_push       = w_event_req;
  assign q_push_valid = w_event_req && !w_full;
  assign q_pop        = en;
  assign q_pop_valid  = en && !w_empty;
  assign w_both       = w_ev_out.a_present && w_ev_out.b_present;

  // LLC stage 1: latch the popped event and its pacings.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid     <= 1'b0;
      llc_tag        <= '0;
      pacing_0       <= 1'b0;
      pacing_1       <= 1'b0;
      pacing_2       <= 1'b0;
      slide_0        <= 1'b0;
      out0_data0_tag <= '0;
      out0_data0_int <= '0;
      out0_data1_tag <= '0;
      out0_data1_int <= '0;
    end else if (en) begin
      r_s1_valid <= q_pop_valid;
      pacing_0   <= q_pop_valid && w_both;
      pacing_2   <= q_pop_valid && w_both;
      pacing_1   <= q_pop_valid && w_ev_out.periodic;
      slide_0    <= q_pop_valid && w_ev_out.periodic;
      if (q_pop_valid) llc_tag <= w_ev_out.tag;
      if (q_pop_valid && w_both) begin
        out0_data0_tag <= w_ev_out.tag;
        out0_data0_int <= w_ev_out.a;
        out0_data1_tag <= w_ev_out.tag;
        out0_data1_int <= w_ev_out.b;
      end
    end
  end

  assign w_o0     = out0_data0_int + out0_data1_int;
  assign w_bucket = sw0_v1 + (pacing_0 ? w_o0 : 64'd0);

  // LLC stage 2: output_2 reads history before the shift; output_1 includes
  // this event's sum before the window slides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_0      <= '0;
      output_1      <= '0;
      output_2      <= '0;
      output_0_aktv <= 1'b0;
      output_1_aktv <= 1'b0;
      output_2_aktv <= 1'b0;
      out0_tag1     <= '0;
      out0_v1       <= '0;
      out0_tag2     <= '0;
      out0_v2       <= '0;
      out0_tag3     <= '0;
      out0_v3       <= '0;
      sw0_tag       <= '0;
      sw0_v1        <= '0;
      sw0_v2        <= '0;
      sw0_v3        <= '0;
    end else if (en) begin
      output_0_aktv <= pacing_0;
      output_1_aktv <= pacing_1;
      output_2_aktv <= pacing_2;
      if (pacing_2) output_2 <= out0_v2;
      if (pacing_0) begin
        output_0  <= w_o0;
        out0_tag3 <= out0_tag2;
        out0_v3   <= out0_v2;
        out0_tag2 <= out0_tag1;
        out0_v2   <= out0_v1;
        out0_tag1 <= out0_data0_tag;
        out0_v1   <= w_o0;
      end
      if (r_s1_valid) sw0_tag <= llc_tag;
      if (pacing_1) begin
        output_1 <= w_bucket + sw0_v2 + sw0_v3;
        sw0_v3   <= sw0_v2;
        sw0_v2   <= w_bucket;
        sw0_v1   <= '0;
      end else begin
        sw0_v1 <= w_bucket;
      end
    end
  end

endmodule

// File: tb/tb_top_entity.sv
// Randomized bench for top_entity against an event-level reference model.
module tb_top_entity;

  localparam int unsigned P  = 20;
  localparam int unsigned QD = 4;

  logic        clk = 1'b0;
  logic        rst, en, ni0, ni1;
  logic [63:0] in0, in1;
  logic [63:0] output_0, output_1, output_2, llc_tag, sw0_tag, sw0_v1, sw0_v2, sw0_v3;
  logic [63:0] out0_data0_tag, out0_data0_int, out0_data1_tag, out0_data1_int;
  logic [63:0] out0_tag1, out0_v1, out0_tag2, out0_v2, out0_tag3, out0_v3;
  logic        output_0_aktv, output_1_aktv, output_2_aktv;
  logic        q_push, q_pop, q_push_valid, q_pop_valid;
  logic        pacing_0, pacing_1, pacing_2, slide_0;

  always #5 clk = ~clk;

  top_entity #(.PERIOD_CYCLES(P), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .en(en),
    .input_0(in0), .new_input_0(ni0), .input_1(in1), .new_input_1(ni1),
    .output_0(output_0), .output_0_aktv(output_0_aktv),
    .output_1(output_1), .output_1_aktv(output_1_aktv),
    .output_2(output_2), .output_2_aktv(output_2_aktv),
    .llc_tag(llc_tag), .q_push(q_push), .q_pop(q_pop),
    .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid),
    .pacing_0(pacing_0), .pacing_1(pacing_1), .pacing_2(pacing_2), .slide_0(slide_0),
    .sw0_tag(sw0_tag), .sw0_v1(sw0_v1), .sw0_v2(sw0_v2), .sw0_v3(sw0_v3),
    .out0_data0_tag(out0_data0_tag), .out0_data0_int(out0_data0_int),
    .out0_data1_tag(out0_data1_tag), .out0_data1_int(out0_data1_int),
    .out0_tag1(out0_tag1), .out0_v1(out0_v1), .out0_tag2(out0_tag2),
    .out0_v2(out0_v2), .out0_tag3(out0_tag3), .out0_v3(out0_v3)
  );

  typedef struct {
    logic [63:0] tag, a, b;
    logic        ap, bp, per;
  } mev_t;

  typedef struct {
    int unsigned due;
    logic [63:0] tag;
    logic        p0, per;
    logic [63:0] o0, o1, o2;
  } rec_t;

  mev_t        mq[$];
  rec_t        s1q[$], s2q[$];
  logic [63:0] vals[$];
  int unsigned vper[$];
  int unsigned period, mc, j;
  logic [63:0] mtag, cur_tag, cur_o0, cur_o1, cur_o2;
  logic [3:0]  cur_pac;
  logic [2:0]  cur_akt;
  logic        last_en;
  int          n_cmp = 0, n_bad = 0, pv_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, j);
    end
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 0) v = 64'($urandom_range(0, 50)) - 64'd25;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete(); s1q.delete(); s2q.delete(); vals.delete(); vper.delete();
    period = 0; mc = 0; mtag = '0; cur_tag = '0;
    cur_o0 = '0; cur_o1 = '0; cur_o2 = '0; cur_pac = '0; cur_akt = '0; last_en = 1'b0;
  endtask

  // Reference: output_2 is the value two evaluations back; output_1 sums every
  // output_0 value that fell within the current or two preceding periods.
  task automatic evaluate(input mev_t ev);
    rec_t r;
    r.due = j + 2; r.tag = ev.tag; r.p0 = ev.ap && ev.bp; r.per = ev.per;
    r.o0 = '0; r.o1 = '0; r.o2 = '0;
    if (r.p0) begin
      r.o0 = ev.a + ev.b;
      r.o2 = (vals.size() >= 2) ? vals[vals.size()-2] : 64'd0;
      vals.push_back(r.o0);
      vper.push_back(period);
    end
    if (r.per) begin
      for (int i = 0; i < vals.size(); i++)
        if (vper[i] + 2 >= period) r.o1 += vals[i];
      period++;
    end
    s2q.push_back(r);
    r.due = j + 1;
    s1q.push_back(r);
  endtask

  task automatic step(input logic e, input logic na, input logic nb,
                      input logic [63:0] va, input logic [63:0] vb);
    rec_t r;
    logic dl, evq, full, popok;
    @(negedge clk);
    j++;
    if (s1q.size() > 0 && s1q[0].due == j) begin
      r = s1q.pop_front();
      cur_tag = r.tag;
      cur_pac = {r.p0, r.per, r.p0, r.per};
    end else if (last_en) cur_pac = '0;
    if (s2q.size() > 0 && s2q[0].due == j) begin
      r = s2q.pop_front();
      cur_akt = {r.p0, r.per, r.p0};
      if (r.p0) begin cur_o0 = r.o0; cur_o2 = r.o2; end
      if (r.per) cur_o1 = r.o1;
    end else if (last_en) cur_akt = '0;
    check("llc_tag", llc_tag, cur_tag);
    check("pacing", {60'd0, pacing_0, pacing_1, pacing_2, slide_0}, {60'd0, cur_pac});
    check("aktv", {61'd0, output_0_aktv, output_1_aktv, output_2_aktv}, {61'd0, cur_akt});
    check("output_0", output_0, cur_o0);
    check("output_1", output_1, cur_o1);
    check("output_2", output_2, cur_o2);
    check("out0_v1", out0_v1, cur_o0);

    en = e; ni0 = na; ni1 = nb; in0 = va; in1 = vb;
    #1;
    dl    = e && (mc == P - 1);
    evq   = na || nb || dl;
    full  = (mq.size() == QD);
    popok = e && (mq.size() > 0);
    check("q_push", q_push, evq);
    check("q_push_valid", q_push_valid, evq && !full);
    check("q_pop_valid", q_pop_valid, popok);
    if (q_push_valid) pv_cnt++;
    if (popok) evaluate(mq.pop_front());
    if (evq) begin
      mtag++;
      if (!full) mq.push_back('{mtag, va, vb, na, nb, dl});
    end
    if (e) mc = dl ? 0 : mc + 1;
    last_en = e;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; ni0 = 1'b0; ni1 = 1'b0; in0 = '0; in1 = '0;
    repeat (2) @(negedge clk);
    check("rst_output_0", output_0, 64'd0);
    check("rst_output_1", output_1, 64'd0);
    check("rst_output_2", output_2, 64'd0);
    check("rst_aktv", {61'd0, output_0_aktv, output_1_aktv, output_2_aktv}, 64'd0);
    check("rst_llc_tag", llc_tag, 64'd0);
    check("rst_sw0", sw0_tag | sw0_v1 | sw0_v2 | sw0_v3, 64'd0);
    check("rst_hist", out0_v1 | out0_v2 | out0_v3 | out0_tag1, 64'd0);
    check("rst_data", out0_data0_int | out0_data1_int | out0_data0_tag, 64'd0);
    check("rst_q_pop_valid", q_pop_valid, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic quiet();
    for (int i = 0; i < 60; i++) begin
      if (mq.size() == 0 && s1q.size() == 0 && s2q.size() == 0) break;
      step(1, 0, 0, '0, '0);
    end
    check("drain", 64'(mq.size() + s1q.size() + s2q.size()), 64'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; en = 1'b0; ni0 = 1'b0; ni1 = 1'b0; in0 = '0; in1 = '0; j = 0;
    model_reset();
    do_reset();

    repeat (25) step(1, 0, 0, '0, '0);
    step(1, 1, 1, 64'd1, 64'd1);
    step(1, 1, 1, 64'd2, 64'd2);
    step(1, 1, 1, 64'd3, 64'd3);
    repeat (4) step(1, 0, 0, '0, '0);
    step(1, 1, 1, 64'd1, 64'd1);
    repeat (4 * P + 5) step(1, 0, 0, '0, '0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < P && mc != P - 1; i++) step(1, 0, 0, '0, '0);
      step(1, 1, 1, rnd64(), rnd64());
      step(1, 1, 0, rnd64(), rnd64());
      step(1, 0, 1, rnd64(), rnd64());
    end

    for (int i = 0; i < 400; i++)
      step(1, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, rnd64(), rnd64());

    quiet();
    base = pv_cnt;
    for (int i = 0; i < QD + 3; i++) step(0, 1, 1, rnd64(), rnd64());
    check("accepted_while_stalled", 64'(pv_cnt - base), 64'(QD));
    repeat (10) step(1, 0, 0, '0, '0);

    quiet();
    for (int i = 0; i < 3; i++) step(0, 1, 1, rnd64(), rnd64());
    do_reset();
    repeat (6) step(1, 0, 0, '0, '0);
    repeat (2 * P) step(1, $urandom_range(0, 1) != 0, 1'b1, rnd64(), rnd64());
    quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", j);
    $fatal(1);
  end

endmodule
